// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO mode constants and helpers, reusable by single- and dual-clock FIFOs.
package fifo_pkg;
    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int fifo_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Explicit wrap so non-power-of-two depths work.
    function automatic int unsigned fifo_ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: flop-array storage, one write port, registered or fall-through read port.
module sync_fifo_mem import fifo_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int FWFT       = FIFO_MODE_STD,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) rd_q <= '0;
        else if (re_i) rd_q <= mem_q[raddr_i];
    end

    assign rdata_o = (FWFT == FIFO_MODE_FWFT) ? mem_q[raddr_i] : rd_q;
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, any depth >= 2, standard or FWFT read, thresholds and error pulses.
module sync_fifo import fifo_pkg::*; #(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 8,
    parameter int FWFT          = FIFO_MODE_STD,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  wr_en_i,
    input  logic [DATA_WIDTH-1:0]                 wr_data_i,
    input  logic                                  rd_en_i,
    output logic [DATA_WIDTH-1:0]                 rd_data_o,
    output logic                                  full_o,
    output logic                                  empty_o,
    output logic                                  almost_full_o,
    output logic                                  almost_empty_o,
    output logic [fifo_cnt_width(FIFO_DEPTH)-1:0] count_o,
    output logic                                  overflow_o,
    output logic                                  underflow_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = fifo_cnt_width(FIFO_DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d, unf_q, unf_d, wr_acc, rd_acc;

    assign empty_o        = count_q == '0;
    assign full_o         = count_q == CW'(FIFO_DEPTH);
    assign almost_full_o  = int'(count_q) >= AFULL_THRESH;
    assign almost_empty_o = int'(count_q) <= AEMPTY_THRESH;
    assign count_o        = count_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

    // A full FIFO still takes a write when the same cycle frees a slot.
    always_comb begin
        rd_acc   = rd_en_i & ~empty_o;
        wr_acc   = wr_en_i & (~full_o | rd_acc);
        wr_ptr_d = wr_acc ? PW'(fifo_ptr_inc(32'(wr_ptr_q), FIFO_DEPTH)) : wr_ptr_q;
        rd_ptr_d = rd_acc ? PW'(fifo_ptr_inc(32'(rd_ptr_q), FIFO_DEPTH)) : rd_ptr_q;
        count_d  = (wr_acc & ~rd_acc) ? count_q + 1'b1 :
                   (rd_acc & ~wr_acc) ? count_q - 1'b1 : count_q;
        ovf_d    = wr_en_i & ~wr_acc;
        unf_d    = rd_en_i & ~rd_acc;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (FIFO_DEPTH),
        .FWFT      (FWFT),
        .AW        (PW)
    ) u_mem (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .we_i   (wr_acc & ~rst_i),
        .waddr_i(wr_ptr_q),
        .wdata_i(wr_data_i),
        .re_i   (rd_acc & ~rst_i),
        .raddr_i(rd_ptr_q),
        .rdata_o(rd_data_o)
    );
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed vector table plus queue-model soak across depths 2, 5, 8 and both read modes.
module tb_sync_fifo;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, wr = 1'b0, rd = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] rdo [4];
    logic       fl [4], em [4], af [4], ae [4], ov [4], un [4];
    logic [2:0] c0, c1;
    logic [1:0] c2;
    logic [3:0] c3;

    int dep [4] = '{5, 5, 2, 8};
    bit fw  [4] = '{0, 1, 0, 1};

    sync_fifo #(.FIFO_DEPTH(5), .FWFT(0)) u0 (.clk_i(clk), .rst_i(rst), .wr_en_i(wr), .wr_data_i(din), .rd_en_i(rd),
        .rd_data_o(rdo[0]), .full_o(fl[0]), .empty_o(em[0]), .almost_full_o(af[0]), .almost_empty_o(ae[0]),
        .count_o(c0), .overflow_o(ov[0]), .underflow_o(un[0]));
    sync_fifo #(.FIFO_DEPTH(5), .FWFT(1)) u1 (.clk_i(clk), .rst_i(rst), .wr_en_i(wr), .wr_data_i(din), .rd_en_i(rd),
        .rd_data_o(rdo[1]), .full_o(fl[1]), .empty_o(em[1]), .almost_full_o(af[1]), .almost_empty_o(ae[1]),
        .count_o(c1), .overflow_o(ov[1]), .underflow_o(un[1]));
    sync_fifo #(.FIFO_DEPTH(2), .FWFT(0)) u2 (.clk_i(clk), .rst_i(rst), .wr_en_i(wr), .wr_data_i(din), .rd_en_i(rd),
        .rd_data_o(rdo[2]), .full_o(fl[2]), .empty_o(em[2]), .almost_full_o(af[2]), .almost_empty_o(ae[2]),
        .count_o(c2), .overflow_o(ov[2]), .underflow_o(un[2]));
    sync_fifo #(.FIFO_DEPTH(8), .FWFT(1)) u3 (.clk_i(clk), .rst_i(rst), .wr_en_i(wr), .wr_data_i(din), .rd_en_i(rd),
        .rd_data_o(rdo[3]), .full_o(fl[3]), .empty_o(em[3]), .almost_full_o(af[3]), .almost_empty_o(ae[3]),
        .count_o(c3), .overflow_o(ov[3]), .underflow_o(un[3]));

    typedef struct {
        bit rst; bit wr; logic [7:0] din; bit rd;
        int cnt; bit em; bit fl; bit af; bit ae; bit ov; bit un;
        logic [7:0] rs; logic [7:0] rf;
    } vec_t;
    vec_t tv [31];

    int total = 0, bad = 0;
    logic [7:0] mq [4][$];
    logic [7:0] erd [4];
    bit eov [4], eun [4];

    function automatic logic [31:0] cnt_of(input int k);
        return k == 0 ? 32'(c0) : k == 1 ? 32'(c1) : k == 2 ? 32'(c2) : 32'(c3);
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, k, $time, act, exp);
        end
    endtask

    task automatic model();
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                mq[k].delete();
                erd[k] = '0; eov[k] = 1'b0; eun[k] = 1'b0;
            end else begin
                bit ra, wa;
                ra = rd && mq[k].size() > 0;
                wa = wr && (mq[k].size() < dep[k] || ra);
                eov[k] = wr && !wa;
                eun[k] = rd && !ra;
                if (ra) erd[k] = mq[k].pop_front();
                if (wa) mq[k].push_back(din);
            end
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 4; k++) begin
            int n;
            n = mq[k].size();
            chk("m_count", k, cnt_of(k), 32'(n));
            chk("m_empty", k, 32'(em[k]), 32'(n == 0));
            chk("m_full", k, 32'(fl[k]), 32'(n == dep[k]));
            chk("m_afull", k, 32'(af[k]), 32'(n >= dep[k] - 1));
            chk("m_aempty", k, 32'(ae[k]), 32'(n <= 1));
            chk("m_ovf", k, 32'(ov[k]), 32'(eov[k]));
            chk("m_unf", k, 32'(un[k]), 32'(eun[k]));
            if (!fw[k]) chk("m_rdata", k, 32'(rdo[k]), 32'(erd[k]));
            else if (n > 0) chk("m_rdata", k, 32'(rdo[k]), 32'(mq[k][0]));
        end
    endtask

    task automatic step(input bit r, input bit w, input logic [7:0] d, input bit p);
        rst = r; wr = w; din = d; rd = p;
        @(posedge clk);
        model();
        #1;
        check_model();
    endtask

    initial begin
        tv = '{
            '{1,0,8'h00,0, 0,1,0,0,1,0,0, 8'h00,8'h00},
            '{0,1,8'h01,0, 1,0,0,0,1,0,0, 8'h00,8'h01},
            '{0,1,8'h02,0, 2,0,0,0,0,0,0, 8'h00,8'h01},
            '{0,1,8'h03,0, 3,0,0,0,0,0,0, 8'h00,8'h01},
            '{0,1,8'h04,0, 4,0,0,1,0,0,0, 8'h00,8'h01},
            '{0,1,8'h05,0, 5,0,1,1,0,0,0, 8'h00,8'h01},
            '{0,1,8'h06,0, 5,0,1,1,0,1,0, 8'h00,8'h01},
            '{0,0,8'h00,0, 5,0,1,1,0,0,0, 8'h00,8'h01},
            '{0,0,8'h00,1, 4,0,0,1,0,0,0, 8'h01,8'h02},
            '{0,0,8'h00,1, 3,0,0,0,0,0,0, 8'h02,8'h03},
            '{0,0,8'h00,1, 2,0,0,0,0,0,0, 8'h03,8'h04},
            '{0,0,8'h00,1, 1,0,0,0,1,0,0, 8'h04,8'h05},
            '{0,0,8'h00,1, 0,1,0,0,1,0,0, 8'h05,8'h00},
            '{0,0,8'h00,1, 0,1,0,0,1,0,1, 8'h05,8'h00},
            '{0,0,8'h00,0, 0,1,0,0,1,0,0, 8'h05,8'h00},
            '{0,1,8'h0A,1, 1,0,0,0,1,0,1, 8'h05,8'h0A},
            '{0,1,8'h0B,0, 2,0,0,0,0,0,0, 8'h05,8'h0A},
            '{0,1,8'h0C,0, 3,0,0,0,0,0,0, 8'h05,8'h0A},
            '{0,1,8'h0D,0, 4,0,0,1,0,0,0, 8'h05,8'h0A},
            '{0,1,8'h0E,0, 5,0,1,1,0,0,0, 8'h05,8'h0A},
            '{0,1,8'h0F,1, 5,0,1,1,0,0,0, 8'h0A,8'h0B},
            '{0,1,8'h10,1, 5,0,1,1,0,0,0, 8'h0B,8'h0C},
            '{0,1,8'h11,1, 5,0,1,1,0,0,0, 8'h0C,8'h0D},
            '{0,1,8'h12,1, 5,0,1,1,0,0,0, 8'h0D,8'h0E},
            '{0,1,8'h13,1, 5,0,1,1,0,0,0, 8'h0E,8'h0F},
            '{0,0,8'h00,1, 4,0,0,1,0,0,0, 8'h0F,8'h10},
            '{0,0,8'h00,1, 3,0,0,0,0,0,0, 8'h10,8'h11},
            '{1,1,8'h55,0, 0,1,0,0,1,0,0, 8'h00,8'h00},
            '{0,0,8'h00,0, 0,1,0,0,1,0,0, 8'h00,8'h00},
            '{0,1,8'hA5,0, 1,0,0,0,1,0,0, 8'h00,8'hA5},
            '{0,0,8'h00,1, 0,1,0,0,1,0,0, 8'hA5,8'h00}
        };
        for (int i = 0; i < 31; i++) begin
            step(tv[i].rst, tv[i].wr, tv[i].din, tv[i].rd);
            chk("v_count", i, cnt_of(0), 32'(tv[i].cnt));
            chk("v_empty", i, 32'(em[0]), 32'(tv[i].em));
            chk("v_full", i, 32'(fl[0]), 32'(tv[i].fl));
            chk("v_afull", i, 32'(af[0]), 32'(tv[i].af));
            chk("v_aempty", i, 32'(ae[0]), 32'(tv[i].ae));
            chk("v_ovf", i, 32'(ov[0]), 32'(tv[i].ov));
            chk("v_unf", i, 32'(un[0]), 32'(tv[i].un));
            chk("v_rd_std", i, 32'(rdo[0]), 32'(tv[i].rs));
            chk("v_fw_empty", i, 32'(em[1]), 32'(tv[i].em));
            if (!tv[i].em) chk("v_rd_fwft", i, 32'(rdo[1]), 32'(tv[i].rf));
        end
        // Alternate write-heavy and read-heavy phases so every depth hits full and empty.
        for (int c = 0; c < 4000; c++) begin
            int pw;
            pw = ((c / 500) % 2 == 1) ? 30 : 75;
            step($urandom_range(0, 299) == 0, $urandom_range(0, 99) < pw, 8'($urandom),
                 $urandom_range(0, 99) < (100 - pw));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
